// File: rtl/bldc_commutator.sv
// BLDC six-step commutator: filtered hall decode, PWM with period-aligned duty
// update, dead-time gate sequencing, invalid-hall fault latch and hall-period timer.
module bldc_commutator #(
  parameter int unsigned FILTER_CYCLES = 8,
  parameter int unsigned DEAD_CYCLES   = 24,
  parameter int unsigned PERIOD_W      = 24
) (
  input  logic                iCLK,
  input  logic                iRESETn,
  input  logic                iENABLE,
  input  logic                iDIR,
  input  logic [10:0]         iDUTY,
  input  logic [2:0]          iHALL,
  input  logic                iFAULT_CLR,
  output logic [5:0]          oPHASES,
  output logic [2:0]          oHALL_CODE,
  output logic                oFAULT,
  output logic [PERIOD_W-1:0] oHALL_PERIOD,
  output logic                oPERIOD_VALID
);

  localparam int unsigned PWM_W  = 11;
  localparam int unsigned FILT_W = 8;
  localparam int unsigned DEAD_W = 8;
  localparam int unsigned HALL_W = 3;
  localparam int unsigned PH_W   = 6;

  localparam logic [FILT_W-1:0]   FILT_MAX   = '1;
  localparam logic [FILT_W-1:0]   FILT_THR   = FILT_W'(FILTER_CYCLES);
  localparam logic [DEAD_W-1:0]   DEAD_LOAD  = DEAD_W'(DEAD_CYCLES);
  localparam logic [PERIOD_W-1:0] PERIOD_MAX = '1;
  localparam logic [PWM_W-1:0]    PWM_TOP    = '1;

  logic [HALL_W-1:0]   r_hall_s1;
  logic [HALL_W-1:0]   r_hall_s2;
  logic [HALL_W-1:0]   r_hall_prev;
  logic [FILT_W-1:0]   r_filt_cnt;
  logic [HALL_W-1:0]   r_hall_code;
  logic                r_fault;
  logic [PERIOD_W-1:0] r_per_cnt;
  logic [PERIOD_W-1:0] r_period;
  logic                r_period_valid;
  logic [PWM_W-1:0]    r_pwm_cnt;
  logic [PWM_W-1:0]    r_duty;
  logic [DEAD_W-1:0]   r_dead;
  logic [PH_W-1:0]     r_target_prev;
  logic [PH_W-1:0]     r_phases;

  logic [FILT_W-1:0]   w_filt_nxt;
  logic                w_accept;
  logic                w_new_invalid;
  logic                w_code_valid;
  logic                w_pwm_on;
  logic [PH_W-1:0]     w_fwd;
  logic [PH_W-1:0]     w_target;
  logic                w_reload;
  logic                w_turn_on;

  // Two-flop synchroniser plus previous-sample register for the stability filter
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_hall_s1   <= '0;
      r_hall_s2   <= '0;
      r_hall_prev <= '0;
      r_filt_cnt  <= '0;
    end else begin
      r_hall_s1   <= iHALL;
      r_hall_s2   <= r_hall_s1;
      r_hall_prev <= r_hall_s2;
      r_filt_cnt  <= w_filt_nxt;
    end
  end

  // Number of consecutive cycles the synchronised sample has held its value
  always_comb begin
    w_filt_nxt = r_filt_cnt;
    if (r_hall_s2 != r_hall_prev) begin
      w_filt_nxt = FILT_W'(1);
    end else if (r_filt_cnt != FILT_MAX) begin
      w_filt_nxt = r_filt_cnt + FILT_W'(1);
    end
  end

  assign w_accept      = (w_filt_nxt >= FILT_THR) && (r_hall_s2 != r_hall_code);
  assign w_new_invalid = (r_hall_s2 == 3'b000) || (r_hall_s2 == 3'b111);
  assign w_code_valid  = (r_hall_code != 3'b000) && (r_hall_code != 3'b111);

  // Accepted code, fault latch (set wins over clear) and hall-period timer
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_hall_code    <= '0;
      r_fault        <= 1'b0;
      r_per_cnt      <= '0;
      r_period       <= '0;
      r_period_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hall_code <= r_hall_s2;
      end
      if (w_accept && w_new_invalid) begin
        r_fault <= 1'b1;
      end else if (iFAULT_CLR && w_code_valid) begin
        r_fault <= 1'b0;
      end
      if (w_accept && !w_new_invalid) begin
        r_period       <= r_per_cnt;
        r_period_valid <= 1'b1;
        r_per_cnt      <= PERIOD_W'(1);
      end else begin
        r_period_valid <= 1'b0;
        if (r_per_cnt != PERIOD_MAX) begin
          r_per_cnt <= r_per_cnt + PERIOD_W'(1);
        end
      end
    end
  end

  // Free-running PWM; duty only changes at the wrap so no period is truncated
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      if (r_pwm_cnt == PWM_TOP) begin
        r_duty <= iDUTY;
      end
    end
  end

  assign w_pwm_on = (r_pwm_cnt < r_duty);

  // Forward six-step table, bits {AH,AL,BH,BL,CH,CL}
  always_comb begin
    w_fwd = '0;
    case (r_hall_code)
      3'd5:    w_fwd = 6'b100100;
      3'd1:    w_fwd = 6'b100001;
      3'd3:    w_fwd = 6'b001001;
      3'd2:    w_fwd = 6'b011000;
      3'd6:    w_fwd = 6'b010010;
      3'd4:    w_fwd = 6'b000110;
      default: w_fwd = '0;
    endcase
  end

  // Reverse swaps high and low gate within each phase
  always_comb begin
    w_target = '0;
    if (iENABLE && !r_fault && w_pwm_on) begin
      if (iDIR) begin
        w_target = {w_fwd[4], w_fwd[5], w_fwd[2], w_fwd[3], w_fwd[0], w_fwd[1]};
      end else begin
        w_target = w_fwd;
      end
    end
  end

  assign w_reload  = (|(w_target & ~r_phases)) && (w_target != r_target_prev);
  assign w_turn_on = w_reload ? (DEAD_LOAD == '0) : (r_dead <= DEAD_W'(1));

  // Turn-off is immediate; turn-on waits for the dead counter to run out
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      r_target_prev <= '0;
      r_dead        <= '0;
      r_phases      <= '0;
    end else begin
      r_target_prev <= w_target;
      if (w_reload) begin
        r_dead <= DEAD_LOAD;
      end else if (r_dead != '0) begin
        r_dead <= r_dead - DEAD_W'(1);
      end
      if (w_target != r_phases) begin
        r_phases <= w_turn_on ? w_target : (r_phases & w_target);
      end
    end
  end

  assign oPHASES       = r_phases;
  assign oHALL_CODE    = r_hall_code;
  assign oFAULT        = r_fault;
  assign oHALL_PERIOD  = r_period;
  assign oPERIOD_VALID = r_period_valid;

endmodule

// File: tb/tb_bldc_commutator.sv
// Directed bench for bldc_commutator: hall accept, PWM/dead-time timing, duty
// update, commutation table, glitch rejection, fault latch, period timer, async reset.
module tb_bldc_commutator;

  localparam int unsigned PW = 14;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          dir;
  logic [10:0]   duty;
  logic [2:0]    hall;
  logic          fclr;
  logic [5:0]    phases;
  logic [2:0]    hcode;
  logic          fault;
  logic [PW-1:0] hperiod;
  logic          pvalid;

  int n_checks;
  int n_errors;
  int n_strobe;
  int cyc;
  int base;
  int snap;

  bldc_commutator #(
    .FILTER_CYCLES(8),
    .DEAD_CYCLES  (24),
    .PERIOD_W     (PW)
  ) dut (
    .iCLK         (clk),
    .iRESETn      (rst_n),
    .iENABLE      (en),
    .iDIR         (dir),
    .iDUTY        (duty),
    .iHALL        (hall),
    .iFAULT_CLR   (fclr),
    .oPHASES      (phases),
    .oHALL_CODE   (hcode),
    .oFAULT       (fault),
    .oHALL_PERIOD (hperiod),
    .oPERIOD_VALID(pvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Opposing gates of one phase must never be on together
  always @(negedge clk) begin
    if (pvalid === 1'b1) n_strobe++;
    if (rst_n === 1'b1) begin
      n_checks++;
      assert (((phases[5] & phases[4]) | (phases[3] & phases[2]) | (phases[1] & phases[0])) === 1'b0)
      else begin
        n_errors++;
        $error("FAIL shoot_through: observed phases %b expected no opposing pair", phases);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int e);
    while ((cyc - base) < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_phases"}, 32'(phases), 32'd0);
    check({tag, "_code"},   32'(hcode),  32'd0);
    check({tag, "_fault"},  32'(fault),  32'd0);
    check({tag, "_period"}, 32'(hperiod), 32'd0);
    check({tag, "_pvalid"}, 32'(pvalid), 32'd0);
  endtask

  logic [2:0] step_code [6];
  logic [5:0] step_ph   [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_strobe = 0;
    cyc      = 0;
    base     = 0;
    step_code = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};
    step_ph   = '{6'b100001, 6'b001001, 6'b011000, 6'b010010, 6'b000110, 6'b100100};

    rst_n = 1'b0;
    en    = 1'b0;
    dir   = 1'b0;
    duty  = 11'd0;
    hall  = 3'b000;
    fclr  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");

    // Release with code 5 on the halls and half duty requested
    rst_n = 1'b1;
    en    = 1'b1;
    duty  = 11'd1024;
    hall  = 3'b101;
    base  = cyc;

    goto(9);
    check("accept_early", 32'(hcode), 32'd0);
    goto(10);
    check("accept_code5", 32'(hcode), 32'd5);
    check("first_pvalid", 32'(pvalid), 32'd1);
    check("first_period", 32'(hperiod), 32'd9);
    goto(11);
    check("pvalid_pulse", 32'(pvalid), 32'd0);

    goto(2047);
    check("duty0_before_wrap", 32'(phases), 32'd0);
    goto(2072);
    check("dead_time_hold", 32'(phases), 32'd0);
    goto(2073);
    check("turn_on_1024", 32'(phases), 32'b100100);

    goto(2500);
    duty = 11'd512;
    goto(3072);
    check("ontime_1024_end", 32'(phases), 32'b100100);
    goto(3073);
    check("offtime_1024", 32'(phases), 32'd0);
    goto(4120);
    check("dead_second", 32'(phases), 32'd0);
    goto(4121);
    check("turn_on_512", 32'(phases), 32'b100100);
    goto(4608);
    check("ontime_512_end", 32'(phases), 32'b100100);
    goto(4609);
    check("offtime_512", 32'(phases), 32'd0);

    goto(5000);
    duty = 11'd0;
    goto(6169);
    check("duty0_a", 32'(phases), 32'd0);
    goto(6500);
    check("duty0_b", 32'(phases), 32'd0);

    duty = 11'd2047;
    goto(8217);
    check("turn_on_2047", 32'(phases), 32'b100100);

    // Short glitch must be rejected by the filter
    goto(8300);
    snap = n_strobe;
    hall = 3'b001;
    goto(8303);
    hall = 3'b101;
    goto(8330);
    check("glitch_code", 32'(hcode), 32'd5);
    check("glitch_phases", 32'(phases), 32'b100100);
    check("glitch_strobe", 32'(n_strobe), 32'(snap));

    // Forward commutation with 5000-cycle dwell
    for (int i = 0; i < 6; i++) begin
      goto(9000 + 5000 * i);
      hall = step_code[i];
      goto(9010 + 5000 * i);
      check("step_pvalid", 32'(pvalid), 32'd1);
      check("step_period", 32'(hperiod), (i == 0) ? 32'd9000 : 32'd5000);
      goto(9050 + 5000 * i);
      check("step_phases", 32'(phases), 32'(step_ph[i]));
    end

    // Direction reversal on code 5
    goto(36000);
    dir = 1'b1;
    goto(36001);
    check("rev_all_off", 32'(phases), 32'd0);
    goto(36024);
    check("rev_dead_end", 32'(phases), 32'd0);
    goto(36025);
    check("rev_on", 32'(phases), 32'b011000);
    goto(36100);
    dir = 1'b0;
    goto(36125);
    check("fwd_again", 32'(phases), 32'b100100);

    // Invalid hall 111 latches the fault
    goto(37000);
    snap = n_strobe;
    hall = 3'b111;
    goto(37020);
    check("fault_set", 32'(fault), 32'd1);
    check("fault_code", 32'(hcode), 32'd7);
    check("fault_phases", 32'(phases), 32'd0);
    goto(37030);
    fclr = 1'b1;
    goto(37031);
    fclr = 1'b0;
    goto(37035);
    check("fault_clr_invalid", 32'(fault), 32'd1);
    check("fault_no_strobe", 32'(n_strobe), 32'(snap));
    goto(37040);
    hall = 3'b001;
    goto(37050);
    check("recover_code", 32'(hcode), 32'd1);
    check("recover_period", 32'(hperiod), 32'd3040);
    goto(37060);
    check("fault_still", 32'(fault), 32'd1);
    fclr = 1'b1;
    goto(37061);
    fclr = 1'b0;
    goto(37062);
    check("fault_cleared", 32'(fault), 32'd0);
    goto(37085);
    check("resume_dead", 32'(phases), 32'd0);
    goto(37086);
    check("resume_on", 32'(phases), 32'b100001);

    // Long stall saturates the period counter
    goto(54040);
    hall = 3'b011;
    goto(54050);
    check("period_sat", 32'(hperiod), 32'd16383);

    // Asynchronous reset during dead time
    goto(54060);
    check("pre_reset_dead", 32'(phases), 32'b000001);
    rst_n = 1'b0;
    #1;
    check_reset("reset_dead");
    #3;
    rst_n = 1'b1;
    base  = cyc;

    // Asynchronous reset during on-time
    goto(10);
    check("reaccept_code3", 32'(hcode), 32'd3);
    goto(2100);
    check("pre_reset_on", 32'(phases), 32'b001001);
    rst_n = 1'b0;
    #1;
    check_reset("reset_on");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
